// File: rtl/reset_seq.sv
// Reset sequencer: synchronizes reset_n deassertion, then releases NUM_STAGES
// active-high synchronous reset lines one at a time with a fixed spacing.
module reset_seq #(
    parameter int unsigned NUM_STAGES  = 4,
    parameter int unsigned SYNC_DEPTH  = 2,
    parameter int unsigned STAGE_DELAY = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sw_rst_req_i,
    output logic [NUM_STAGES-1:0] rst_stage_o,
    output logic                  ready_o,
    output logic                  sw_rst_ack_o,
    output logic [1:0]            state_o
);

    localparam int unsigned CNT_W = $clog2(STAGE_DELAY + 1);
    localparam int unsigned IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STAGE_DELAY - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_STAGES - 1);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2,
        ST_SW_HOLD = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [SYNC_DEPTH-1:0] sync_q;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  pend_q, pend_d;
    logic [NUM_STAGES-1:0] stage_q, stage_d;
    logic                  ready_q, ready_d;
    logic                  ack_q, ack_d;
    logic                  rst_sync;

    assign rst_sync = sync_q[SYNC_DEPTH-1];

    // State and output registers; reset_n forces everything back asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
            idx_q   <= '0;
            pend_q  <= 1'b0;
            stage_q <= '1;
            ready_q <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_DEPTH-2:0], 1'b1};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            stage_q <= stage_d;
            ready_q <= ready_d;
            ack_q   <= ack_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        pend_d  = pend_q;
        stage_d = stage_q;
        ready_d = ready_q;
        ack_d   = 1'b0;

        unique case (state_q)
            ST_ASSERT: begin
                stage_d = '1;
                ready_d = 1'b0;
                if (rst_sync) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            ST_RELEASE: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    idx_d = idx_q + IDX_W'(1);
                    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            stage_d[i] = 1'b0;
                        end
                    end
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_RUN;
                        ready_d = 1'b1;
                        ack_d   = pend_q;
                        pend_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (sw_rst_req_i) begin
                    state_d = ST_SW_HOLD;
                    stage_d = '1;
                    ready_d = 1'b0;
                    cnt_d   = '0;
                    pend_d  = 1'b1;
                end
            end
            ST_SW_HOLD: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_ASSERT;
        endcase
    end

    assign rst_stage_o  = stage_q;
    assign ready_o      = ready_q;
    assign sw_rst_ack_o = ack_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_reset_seq.sv
// Scoreboard bench for reset_seq: two instances (default and 1-stage/1-cycle)
// checked every cycle against a timeline model derived from the release formulas.
module tb_reset_seq;

    localparam int M_HELD = 0;
    localparam int M_POR  = 1;
    localparam int M_SW   = 2;

    typedef struct packed {
        logic [3:0] stage;
        logic       ready;
        logic       ack;
        logic [1:0] state;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       sw_req;
    logic [3:0] stage0;
    logic       ready0, ack0;
    logic [1:0] state0;
    logic [0:0] stage1;
    logic       ready1, ack1;
    logic [1:0] state1;

    int n_tests = 0;
    int n_fail  = 0;

    int p_n [2] = '{4, 1};
    int p_s [2] = '{2, 2};
    int p_d [2] = '{8, 1};
    int mode [2] = '{M_HELD, M_HELD};
    int k    [2] = '{0, 0};
    exp_t q0 [$];
    exp_t q1 [$];

    reset_seq #(.NUM_STAGES(4), .SYNC_DEPTH(2), .STAGE_DELAY(8)) dut0 (
        .clk(clk), .reset_n(reset_n), .sw_rst_req_i(sw_req),
        .rst_stage_o(stage0), .ready_o(ready0), .sw_rst_ack_o(ack0), .state_o(state0)
    );

    reset_seq #(.NUM_STAGES(1), .SYNC_DEPTH(2), .STAGE_DELAY(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .sw_rst_req_i(sw_req),
        .rst_stage_o(stage1), .ready_o(ready1), .sw_rst_ack_o(ack1), .state_o(state1)
    );

    always #5 clk = ~clk;

    // Expected outputs from the timeline: k is the edge count since the reference event.
    function automatic exp_t model(input int nst, input int sd, input int dly,
                                   input int md, input int kk);
        exp_t e;
        int   r;
        int   ones;
        ones    = (1 << nst) - 1;
        e.stage = 4'(ones);
        e.ready = 1'b0;
        e.ack   = 1'b0;
        e.state = 2'd0;
        r       = -1;
        if (md == M_POR && kk > sd) begin
            r = (kk - sd - 1) / dly;
        end else if (md == M_SW) begin
            if (kk < dly) e.state = 2'd3;
            else          r = (kk - dly) / dly;
            e.ack = (kk == (nst + 1) * dly);
        end
        if (r >= 0) begin
            if (r > nst) r = nst;
            e.stage = 4'((ones >> r) << r);
            e.state = (r == nst) ? 2'd2 : 2'd1;
            e.ready = (r == nst);
        end
        return e;
    endfunction

    // Reference timeline bookkeeping.
    always @(posedge clk or negedge reset_n) begin
        for (int i = 0; i < 2; i++) begin
            exp_t cur;
            cur = model(p_n[i], p_s[i], p_d[i], mode[i], k[i]);
            if (!reset_n) begin
                mode[i] = M_HELD;
                k[i]    = 0;
            end else if (mode[i] == M_HELD) begin
                mode[i] = M_POR;
                k[i]    = 1;
            end else if (cur.state == 2'd2 && sw_req) begin
                mode[i] = M_SW;
                k[i]    = 0;
            end else begin
                k[i] = k[i] + 1;
            end
        end
    end

    // Push the expectation for the current cycle.
    always @(negedge clk) begin
        q0.push_back(model(p_n[0], p_s[0], p_d[0], mode[0], k[0]));
        q1.push_back(model(p_n[1], p_s[1], p_d[1], mode[1], k[1]));
    end

    // Monitor: pop and compare once per cycle, away from the active edge.
    always @(negedge clk) begin
        exp_t want;
        exp_t got;
        #1;
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (i == 0) got = '{stage: stage0, ready: ready0, ack: ack0, state: state0};
            else        got = '{stage: {3'b000, stage1}, ready: ready1, ack: ack1, state: state1};
            if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                n_fail++;
                $display("FAIL sb_empty inst%0d t=%0t: no expectation queued", i, $time);
            end else begin
                want = (i == 0) ? q0.pop_front() : q1.pop_front();
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL sb inst%0d t=%0t: got stage=%b rdy=%b ack=%b st=%0d, want stage=%b rdy=%b ack=%b st=%0d",
                             i, $time, got.stage, got.ready, got.ack, got.state,
                             want.stage, want.ready, want.ack, want.state);
                end
            end
        end
    end

    task automatic pulse_sw();
        @(negedge clk); #2 sw_req = 1'b1;
        @(negedge clk); #2 sw_req = 1'b0;
    endtask

    // Drop reset_n mid-cycle, check the asynchronous effect before the next edge.
    task automatic drop_reset(input int hold);
        @(negedge clk); #2 reset_n = 1'b0;
        #1;
        n_tests++;
        if (stage0 !== 4'b1111 || ready0 !== 1'b0 || ack0 !== 1'b0 || state0 !== 2'd0 ||
            stage1 !== 1'b1 || ready1 !== 1'b0 || ack1 !== 1'b0 || state1 !== 2'd0) begin
            n_fail++;
            $display("FAIL async_reset t=%0t: got s0=%b r0=%b a0=%b st0=%0d s1=%b r1=%b a1=%b st1=%0d, want all asserted/idle",
                     $time, stage0, ready0, ack0, state0, stage1, ready1, ack1, state1);
        end
        repeat (hold) @(negedge clk);
        #2 reset_n = 1'b1;
    endtask

    task automatic short_pulse();
        @(posedge clk); #1 reset_n = 1'b0;
        #2 reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        sw_req  = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk); #2 reset_n = 1'b1;
        repeat (45) @(negedge clk);
        pulse_sw();                       // accepted by both in RUN
        repeat (50) @(negedge clk);
        drop_reset(3);
        repeat (15) @(negedge clk);
        pulse_sw();                       // inst0 in RELEASE: ignored
        repeat (10) @(negedge clk);
        drop_reset(1);                    // inst0 mid-release
        repeat (50) @(negedge clk);
        pulse_sw();
        repeat (3) @(negedge clk);
        drop_reset(2);                    // inst0 in SW_HOLD: ack lost
        repeat (50) @(negedge clk);
        short_pulse();
        repeat (50) @(negedge clk);
        for (int c = 0; c < 1500; c++) begin
            int r;
            r = int'($urandom_range(0, 199));
            if (r < 8)       pulse_sw();
            else if (r < 10) drop_reset(int'($urandom_range(1, 6)));
            else if (r < 11) short_pulse();
            else             @(negedge clk);
        end
        repeat (3) @(negedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
